// File: rtl/alu_control_fsm_pkg.sv
// Shared opcode, state, flag and instruction-field definitions for the ALU control sequencer.
// Pure definitions: no latency, no flow control.
// Imported by the decoder and the FSM top.
package cpu_pkg;

    localparam int OP_W   = 4;
    localparam int FLAG_W = 5;

    localparam logic [OP_W-1:0] OP_AND = 4'b0001;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0010;
    localparam logic [OP_W-1:0] OP_XOR = 4'b0011;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0101;
    localparam logic [OP_W-1:0] OP_SUB = 4'b1001;
    localparam logic [OP_W-1:0] OP_CMP = 4'b1011;
    localparam logic [OP_W-1:0] OP_MOV = 4'b1101;

    // Flag vector is packed {C,L,F,Z,N}
    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    localparam int MAJOR_HI = 15;
    localparam int MAJOR_LO = 12;
    localparam int RDEST_HI = 11;
    localparam int RDEST_LO = 8;
    localparam int EXT_HI   = 7;
    localparam int EXT_LO   = 4;
    localparam int RSRC_HI  = 3;
    localparam int RSRC_LO  = 0;
    localparam int IMM_HI   = 7;
    localparam int IMM_LO   = 0;
    localparam int IMM_W    = IMM_HI - IMM_LO + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DECODE    = 2'd1,
        EXECUTE   = 2'd2,
        WRITEBACK = 2'd3
    } state_t;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        case (op)
            OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_CMP, OP_MOV: op_is_legal = 1'b1;
            default:                                               op_is_legal = 1'b0;
        endcase
    endfunction

    // Arithmetic and move immediates are signed; logical immediates are bit masks
    function automatic logic op_imm_signed(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_CMP, OP_MOV: op_imm_signed = 1'b1;
            default:                        op_imm_signed = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_control_fsm_decoder.sv
// Combinational instruction decoder: fields, immediate extension, write-suppress, illegal.
// Latency: zero (pure combinational).
// Backpressure: none; the FSM decides when the outputs are sampled.
module instr_decoder
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] instr,
    output logic [OP_W-1:0]   opcode,
    output logic [3:0]        rdest,
    output logic [3:0]        rsrc,
    output logic              imm_sel,
    output logic [DATA_W-1:0] imm_data,
    output logic              wr_suppress,
    output logic              illegal
);

    logic [3:0]       major;
    logic [IMM_W-1:0] imm_raw;

    assign major   = instr[MAJOR_HI:MAJOR_LO];
    assign imm_raw = instr[IMM_HI:IMM_LO];

    always_comb begin
        imm_sel     = (major != 4'b0000);
        opcode      = imm_sel ? major : instr[EXT_HI:EXT_LO];
        rdest       = instr[RDEST_HI:RDEST_LO];
        rsrc        = instr[RSRC_HI:RSRC_LO];
        illegal     = !op_is_legal(opcode);
        wr_suppress = illegal || (opcode == OP_CMP);
        imm_data    = '0;
        if (imm_sel) begin
            if (op_imm_signed(opcode))
                imm_data = {{(DATA_W-IMM_W){imm_raw[IMM_W-1]}}, imm_raw};
            else
                imm_data = {{(DATA_W-IMM_W){1'b0}}, imm_raw};
        end
    end

endmodule

// File: rtl/alu_control_fsm.sv
// ALU control sequencer: IDLE->DECODE->EXECUTE->WRITEBACK, one instruction per 4 cycles.
// Latency: write enable and done appear 3 cycles after the accepting edge; flags latch at end of WRITEBACK.
// Backpressure: instr_ready is high only in IDLE; the producer holds instr_valid/instr until accepted.
module alu_control_fsm
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         instr,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [FLAG_W-1:0]         flags_in,
    output logic [OP_W-1:0]           alu_opcode,
    output logic [$clog2(NREG)-1:0]   mux_a_sel,
    output logic [$clog2(NREG)-1:0]   mux_b_sel,
    output logic                      imm_sel,
    output logic [DATA_W-1:0]         imm_data,
    output logic [NREG-1:0]           reg_enable,
    output logic [FLAG_W-1:0]         flags_out,
    output logic                      done,
    output logic                      illegal_op
);

    localparam int SEL_W = $clog2(NREG);

    state_t state_q, state_d;
    logic   accept;

    logic [DATA_W-1:0] instr_q;
    logic              wr_suppress_q;
    logic              illegal_q;

    logic [OP_W-1:0]   dec_opcode;
    logic [3:0]        dec_rdest;
    logic [3:0]        dec_rsrc;
    logic              dec_imm_sel;
    logic [DATA_W-1:0] dec_imm_data;
    logic              dec_wr_suppress;
    logic              dec_illegal;

    instr_decoder #(.DATA_W(DATA_W)) u_decoder (
        .instr       (instr_q),
        .opcode      (dec_opcode),
        .rdest       (dec_rdest),
        .rsrc        (dec_rsrc),
        .imm_sel     (dec_imm_sel),
        .imm_data    (dec_imm_data),
        .wr_suppress (dec_wr_suppress),
        .illegal     (dec_illegal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (instr_valid && instr_ready) begin
                    accept  = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE:    state_d = EXECUTE;
            EXECUTE:   state_d = WRITEBACK;
            WRITEBACK: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Ready is registered so it stays low through reset and rises on the first edge after
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) instr_ready <= 1'b0;
        else        instr_ready <= (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      instr_q <= '0;
        else if (accept) instr_q <= instr;
    end

    // Selects load once at the end of DECODE and hold until the next instruction decodes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_opcode    <= '0;
            mux_a_sel     <= '0;
            mux_b_sel     <= '0;
            imm_sel       <= 1'b0;
            imm_data      <= '0;
            wr_suppress_q <= 1'b0;
            illegal_q     <= 1'b0;
        end else if (state_q == DECODE) begin
            alu_opcode    <= dec_opcode;
            mux_a_sel     <= SEL_W'(dec_rdest);
            mux_b_sel     <= SEL_W'(dec_rsrc);
            imm_sel       <= dec_imm_sel;
            imm_data      <= dec_imm_data;
            wr_suppress_q <= dec_wr_suppress;
            illegal_q     <= dec_illegal;
        end
    end

    // Writeback strobes are high exactly while state_q is WRITEBACK
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_enable <= '0;
            done       <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            reg_enable <= '0;
            done       <= 1'b0;
            illegal_op <= 1'b0;
            if (state_q == EXECUTE) begin
                if (!wr_suppress_q)
                    reg_enable <= NREG'(1) << mux_a_sel;
                done       <= 1'b1;
                illegal_op <= illegal_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            flags_out <= '0;
        else if (state_q == WRITEBACK && !illegal_q)
            flags_out <= flags_in;
    end

endmodule

// File: tb/tb_alu_control_fsm.sv
// Randomized bench for alu_control_fsm against an instruction-level reference model.
module tb_alu_control_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  flags_in;
    logic [3:0]  alu_opcode;
    logic [3:0]  mux_a_sel;
    logic [3:0]  mux_b_sel;
    logic        imm_sel;
    logic [15:0] imm_data;
    logic [15:0] reg_enable;
    logic [4:0]  flags_out;
    logic        done;
    logic        illegal_op;

    int checks   = 0;
    int failures = 0;

    // Architecturally visible state held by the model between instructions
    logic [3:0]  m_op, m_a, m_b;
    logic        m_isel;
    logic [15:0] m_imm;
    logic [4:0]  m_flags;

    always #5 clk = ~clk;

    alu_control_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .flags_in    (flags_in),
        .alu_opcode  (alu_opcode),
        .mux_a_sel   (mux_a_sel),
        .mux_b_sel   (mux_b_sel),
        .imm_sel     (imm_sel),
        .imm_data    (imm_data),
        .reg_enable  (reg_enable),
        .flags_out   (flags_out),
        .done        (done),
        .illegal_op  (illegal_op)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_selects(input string tag);
        check({tag, "_op"},   32'(alu_opcode), 32'(m_op));
        check({tag, "_a"},    32'(mux_a_sel),  32'(m_a));
        check({tag, "_b"},    32'(mux_b_sel),  32'(m_b));
        check({tag, "_isel"}, 32'(imm_sel),    32'(m_isel));
        check({tag, "_imm"},  32'(imm_data),   32'(m_imm));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdy"}, 32'(instr_ready), 0);
        check({tag, "_op"},  32'(alu_opcode),  0);
        check({tag, "_a"},   32'(mux_a_sel),   0);
        check({tag, "_b"},   32'(mux_b_sel),   0);
        check({tag, "_isel"},32'(imm_sel),     0);
        check({tag, "_imm"}, 32'(imm_data),    0);
        check({tag, "_ren"}, 32'(reg_enable),  0);
        check({tag, "_flg"}, 32'(flags_out),   0);
        check({tag, "_done"},32'(done),        0);
        check({tag, "_ill"}, 32'(illegal_op),  0);
    endtask

    // Instruction semantics straight from the format rules
    task automatic model(input logic [15:0] ins,
                         output logic [3:0] op, output logic [3:0] a, output logic [3:0] b,
                         output logic isel, output logic [15:0] imm,
                         output logic legal, output logic [15:0] ren);
        int v;
        isel  = (ins[15:12] != 4'd0);
        op    = isel ? ins[15:12] : ins[7:4];
        a     = ins[11:8];
        b     = ins[3:0];
        legal = op inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd9, 4'd11, 4'd13};
        v     = int'(ins[7:0]);
        if (!isel)
            imm = 16'h0000;
        else if ((op inside {4'd5, 4'd9, 4'd11, 4'd13}) && v >= 128)
            imm = 16'(v + 32'hFF00);
        else
            imm = 16'(v);
        ren = (legal && op != 4'd11) ? (16'h0001 << a) : 16'h0000;
    endtask

    // Entered and left at a negedge with the DUT in IDLE
    task automatic run_instr(input logic [15:0] ins, input logic [4:0] fl,
                             input bit b2b, input bit abort);
        logic [3:0]  op, a, b;
        logic        isel, legal;
        logic [15:0] imm, ren;
        int gap;
        gap = b2b ? 0 : int'($urandom_range(0, 2));
        instr_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            instr = 16'($urandom);
            @(negedge clk);
            check("idle_rdy", 32'(instr_ready), 1);
        end
        check("idle_rdy", 32'(instr_ready), 1);
        check("idle_ren", 32'(reg_enable), 0);
        check("idle_done", 32'(done), 0);
        check("idle_ill", 32'(illegal_op), 0);
        check("idle_flg", 32'(flags_out), 32'(m_flags));
        check_selects("idle");
        instr       = ins;
        instr_valid = 1'b1;
        model(ins, op, a, b, isel, imm, legal, ren);

        @(negedge clk);
        // Anything offered while busy must be ignored
        instr       = 16'($urandom);
        instr_valid = b2b ? 1'b1 : 1'($urandom);
        flags_in    = 5'($urandom);
        check("dec_rdy", 32'(instr_ready), 0);
        check("dec_ren", 32'(reg_enable), 0);
        check("dec_done", 32'(done), 0);

        @(negedge clk);
        m_op = op; m_a = a; m_b = b; m_isel = isel; m_imm = imm;
        if (abort) begin
            reset = 1'b0;
            #1;
            check_all_zero("rst_mid");
            m_op = '0; m_a = '0; m_b = '0; m_isel = 1'b0; m_imm = '0; m_flags = '0;
            instr_valid = 1'b0;
            @(negedge clk);
            check_all_zero("rst_hold");
            reset = 1'b1;
            @(negedge clk);
            return;
        end
        check("exe_rdy", 32'(instr_ready), 0);
        check("exe_ren", 32'(reg_enable), 0);
        check("exe_done", 32'(done), 0);
        check_selects("exe");
        flags_in = fl;

        @(negedge clk);
        check("wb_rdy", 32'(instr_ready), 0);
        check("wb_ren", 32'(reg_enable), 32'(ren));
        check("wb_done", 32'(done), 1);
        check("wb_ill", 32'(illegal_op), 32'(!legal));
        check("wb_flg_old", 32'(flags_out), 32'(m_flags));
        check_selects("wb");
        if (legal) m_flags = fl;
        instr       = 16'($urandom);
        instr_valid = b2b ? 1'b1 : 1'b0;

        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b0;
        instr       = '0;
        instr_valid = 1'b0;
        flags_in    = '0;
        m_op = '0; m_a = '0; m_b = '0; m_isel = 1'b0; m_imm = '0; m_flags = '0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_all_zero("reset");
        end
        reset = 1'b1;
        #1;
        check("rel_rdy_pre", 32'(instr_ready), 0);
        @(negedge clk);
        check("rel_rdy", 32'(instr_ready), 1);

        run_instr(16'h0253, 5'b10101, 1'b0, 1'b0);
        run_instr(16'h51FF, 5'b00001, 1'b0, 1'b0);
        run_instr(16'h11FF, 5'b01000, 1'b0, 1'b0);
        run_instr(16'h04B5, 5'b00010, 1'b0, 1'b0);
        run_instr(16'h0F00, 5'b11111, 1'b0, 1'b0);
        run_instr(16'h0353, 5'b00100, 1'b0, 1'b0);
        run_instr(16'hB780, 5'b01101, 1'b0, 1'b0);

        run_instr(16'h0657, 5'b00111, 1'b0, 1'b1);

        for (int i = 0; i < 150; i++)
            run_instr(16'($urandom), 5'($urandom), 1'($urandom), 1'b0);

        for (int i = 0; i < 40; i++)
            run_instr(16'($urandom), 5'($urandom), 1'b1, 1'b0);

        run_instr(16'($urandom), 5'($urandom), 1'b0, 1'b1);
        for (int i = 0; i < 10; i++)
            run_instr(16'($urandom), 5'($urandom), 1'b1, 1'b0);

        instr_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_control_fsm.md
Name: alu_control_fsm

Overview:
- Multi-cycle control sequencer directly upstream of the ALU datapath.
- Accepts one 16-bit instruction per valid/ready handshake and decodes it into opcode, destination and source fields.
- Drives the ALU opcode, both operand-mux selects, the immediate path and the one-hot register write enable, with correct timing.
- Latches ALU flags at writeback and reports completion or illegal-instruction status per instruction.

Parameters:
- DATA_W, 16, datapath and instruction width.
- NREG, 16, register count; sets the reg_enable width and the select width (clog2(NREG) = 4).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr  in  DATA_W  instruction word; sampled only on handshake.
- instr_valid  in  1  upstream has an instruction.
- instr_ready  out  1  FSM can accept an instruction.
- flags_in  in  5  ALU flags {C,L,F,Z,N} from the ALU.
- alu_opcode  out  4  operation code to the ALU.
- mux_a_sel  out  4  register select for operand A (Rdest).
- mux_b_sel  out  4  register select for operand B (Rsrc).
- imm_sel  out  1  1 = operand B comes from imm_data instead of the register mux.
- imm_data  out  DATA_W  extended immediate.
- reg_enable  out  NREG  one-hot register write enable.
- flags_out  out  5  latched flags.
- done  out  1  one-cycle pulse, instruction retired.
- illegal_op  out  1  one-cycle pulse with done when the opcode is undefined.

Behaviour:
- Reset is asynchronous, active-low. While reset=0:
  - state=IDLE.
  - instr_ready=0.
  - All other outputs are 0: alu_opcode, mux_a_sel, mux_b_sel, imm_sel, imm_data, reg_enable, flags_out, done, illegal_op.
  - instr_ready rises to 1 on the first clock edge after reset deasserts.
- Instruction format:
  - [15:12] major op; [11:8] Rdest; [7:4] ext; [3:0] Rsrc.
  - Register form: major=0000. ALU op = ext, operand B = Rsrc.
  - Immediate form: major!=0000. ALU op = major, operand B = instr[7:0].
  - Immediate extension: sign-extended for ADDI, SUBI, CMPI, MOVI; zero-extended for ANDI, ORI, XORI.
- States: IDLE -> DECODE -> EXECUTE -> WRITEBACK -> IDLE. Fixed 4-cycle occupancy, throughput 1 instruction per 4 cycles.
- IDLE:
  - instr_ready=1.
  - On instr_valid && instr_ready, capture instr into an internal register and go to DECODE.
  - Otherwise stay in IDLE.
  - instr is ignored in every other state.
- DECODE:
  - Register alu_opcode, mux_a_sel=Rdest, mux_b_sel=Rsrc, imm_sel and imm_data.
  - Flag an illegal instruction if the op is not in the package opcode list.
- EXECUTE: all selects held stable; the ALU settles.
- WRITEBACK:
  - reg_enable = 1<<Rdest for exactly one cycle. Suppressed (all 0) for CMP/CMPI and for illegal ops.
  - flags_out <= flags_in for every legal op; unchanged on an illegal op.
  - done=1 for this cycle; illegal_op=1 if the op is illegal.
  - Selects are still held this cycle.
- After WRITEBACK, in IDLE:
  - Selects and imm_data retain their last values.
  - reg_enable, done and illegal_op are 0.
- reg_enable is never multi-hot. It is 0 in every state except WRITEBACK.
- Rdest=Rsrc is legal (e.g. ADD r3,r3); no special handling.
- Reset mid-instruction: the instruction is abandoned with no write and no done; all outputs go to their reset values immediately.
- instr_valid may drop without acceptance; no state change results.
- An instruction presented in any non-IDLE state is neither captured nor lost; the producer holds it until instr_ready.

Decomposition:
- Shared package `cpu_pkg`:
  - 4-bit opcode constants: AND=0001, OR=0010, XOR=0011, ADD=0101, SUB=1001, CMP=1011, MOV=1101.
  - Immediate majors reuse the same codes.
  - FSM state enum {IDLE, DECODE, EXECUTE, WRITEBACK}.
  - Flag bit indices C, L, F, Z, N.
  - Instruction field bit positions.
- One natural sub-module: `instr_decoder`, combinational. Takes the instruction word and produces opcode, Rdest, Rsrc, imm_sel, extended immediate, write-suppress and illegal.
- The FSM registers the decoder outputs in DECODE.

Test Plan:
- Reset and ready:
  - Stimulus: hold reset=0 for 3 cycles, then release.
  - Response: all outputs are 0 during reset. instr_ready=1 on the first edge after release.
- Register ADD:
  - Stimulus: instr=16'h0253 (ADD r2,r3).
  - Response: 3 cycles after the handshake, reg_enable=16'h0004, mux_a_sel=2, mux_b_sel=3, alu_opcode=0101, imm_sel=0 and done=1 for one cycle.
- Immediate sign extension:
  - Stimulus: instr=16'h51FF (ADDI r1,-1).
  - Response: imm_sel=1, imm_data=16'hFFFF, reg_enable=16'h0002.
  - Stimulus: instr=16'h11FF (ANDI).
  - Response: imm_data=16'h00FF.
- Compare without writeback:
  - Stimulus: CMP r4,r5 (16'h04B5) with flags_in=5'b00010.
  - Response: reg_enable stays 0 throughout, flags_out=5'b00010 after WRITEBACK, done pulses.
- Illegal op:
  - Stimulus: instr=16'h0F00.
  - Response: done=1 and illegal_op=1 in the same cycle, no reg_enable, flags_out unchanged.
- Reset mid-op and handshake hold:
  - Stimulus: assert reset=0 during EXECUTE.
  - Response: no write, no done, state back to IDLE.
  - Stimulus: keep instr_valid high continuously with back-to-back instructions.
  - Response: exactly one acceptance every 4 cycles, each instruction retired in order.
